// File: rtl/lru_tracker.sv
// lru_tracker: per-set true-LRU age tracker; lru is combinational from the addressed set's ages.
// An access updates the set at the rising edge and the new ordering shows the next cycle; no backpressure.
module lru_tracker #(
   parameter int WIDTH      = 4,
   parameter int INDEX_BITS = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [INDEX_BITS-1:0]    current_index,
   input  logic [$clog2(WIDTH)-1:0] access,
   input  logic                     access_valid,
   output logic [WIDTH-1:0]         lru
);

   localparam int            AW      = $clog2(WIDTH);
   localparam int            SETS    = 1 << INDEX_BITS;
   localparam logic [AW-1:0] AGE_LRU = AW'(WIDTH - 1);

   logic [WIDTH-1:0][AW-1:0] r_age [SETS];
   logic [WIDTH-1:0][AW-1:0] w_set_age;
   logic [WIDTH-1:0][AW-1:0] w_next_age;
   logic [AW-1:0]            w_acc_age;

   assign w_set_age = r_age[current_index];
   assign w_acc_age = w_set_age[access];

   // Only ways younger than the accessed one age; older ways keep their slot,
   // so the set stays a permutation of 0..WIDTH-1.
   always_comb begin
      w_next_age = w_set_age;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_set_age[i] < w_acc_age) begin
            w_next_age[i] = w_set_age[i] + AW'(1);
         end
      end
      w_next_age[access] = '0;
   end

   always_comb begin
      lru = '0;
      for (int i = 0; i < WIDTH; i++) begin
         lru[i] = (w_set_age[i] == AGE_LRU);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++) begin
            for (int i = 0; i < WIDTH; i++) begin
               r_age[s][i] <= AW'(i);
            end
         end
      end else if (access_valid) begin
         r_age[current_index] <= w_next_age;
      end
   end

endmodule

// File: tb/tb_lru_tracker.sv
// Directed bench for lru_tracker: stimulus queues expected lru values, a negedge monitor compares them.
module tb_lru_tracker;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] current_index = '0;
   logic [1:0] access = '0;
   logic       access_valid = 1'b0;
   logic [3:0] lru;

   string      name_q[$];
   logic [3:0] exp_q[$];
   int         n_checks = 0;
   int         n_errors = 0;

   lru_tracker #(.WIDTH(4), .INDEX_BITS(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .current_index(current_index),
      .access       (access),
      .access_valid (access_valid),
      .lru          (lru)
   );

   always #5 clock = ~clock;

   function automatic void expect_lru(input string nm, input logic [3:0] e);
      name_q.push_back(nm);
      exp_q.push_back(e);
   endfunction

   // Drive one cycle's inputs just after the rising edge; e is lru as seen before the next edge.
   task automatic step(input logic [7:0] idx, input logic v, input logic [1:0] w,
                       input string nm, input logic [3:0] e);
      @(posedge clock);
      #1;
      current_index = idx;
      access_valid  = v;
      access        = w;
      expect_lru(nm, e);
   endtask

   initial begin : monitor
      string      nm;
      logic [3:0] e;
      forever begin
         @(negedge clock);
         while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (lru !== e) begin
               n_errors++;
               $display("FAIL %s: lru=%b expected %b", nm, lru, e);
            end
         end
      end
   end

   initial begin : stimulus
      int budget;
      for (int k = 0; k < 5; k++) step(8'd1, 1'b0, 2'd0, "rst_hold", 4'b1000);
      @(posedge clock);
      #1 reset = 1'b1;

      step(8'd1,   1'b0, 2'd0, "rst_idx1",   4'b1000);
      step(8'd0,   1'b0, 2'd0, "rst_idx0",   4'b1000);
      step(8'd255, 1'b0, 2'd0, "rst_idx255", 4'b1000);

      // set 1: {0,1,2,3} -> w2 {1,2,0,3} -> w1 {2,0,1,3} -> w3 {3,1,2,0} -> w2 {3,2,0,1} -> w0 {0,3,1,2}
      step(8'd1, 1'b1, 2'd2, "acc2_during",  4'b1000);
      step(8'd1, 1'b0, 2'd0, "acc2_after",   4'b1000);
      step(8'd1, 1'b1, 2'd1, "acc1_during",  4'b1000);
      step(8'd1, 1'b1, 2'd3, "acc1_after",   4'b1000);
      step(8'd1, 1'b0, 2'd0, "acc3_after",   4'b0001);
      step(8'd1, 1'b1, 2'd2, "acc2b_during", 4'b0001);
      step(8'd1, 1'b1, 2'd0, "acc2b_after",  4'b0001);
      step(8'd1, 1'b0, 2'd0, "acc0_after",   4'b0010);

      step(8'd2, 1'b0, 2'd0, "iso_set2",     4'b1000);
      step(8'd1, 1'b0, 2'd0, "iso_restore",  4'b0010);

      step(8'd1, 1'b1, 2'd0, "mru_during",   4'b0010);
      step(8'd1, 1'b0, 2'd0, "mru_after",    4'b0010);

      // set 255: w3 -> {1,2,3,0}
      step(8'd255, 1'b1, 2'd3, "s255_during", 4'b1000);
      step(8'd255, 1'b0, 2'd0, "s255_after",  4'b0100);
      step(8'd1,   1'b0, 2'd0, "s1_kept",     4'b0010);
      step(8'd2,   1'b0, 2'd0, "s2_kept",     4'b1000);

      step(8'd1, 1'b0, 2'd0, "pre_rst", 4'b0010);
      @(posedge clock);
      #1;
      current_index = 8'd1;
      access        = 2'd3;
      access_valid  = 1'b1;
      #2 reset = 1'b0;
      expect_lru("async_rst_now", 4'b1000);
      step(8'd1, 1'b1, 2'd3, "rst_low_acc",  4'b1000);
      step(8'd1, 1'b1, 2'd3, "rst_low_acc2", 4'b1000);
      @(posedge clock);
      #1;
      access_valid = 1'b0;
      reset        = 1'b1;
      expect_lru("rst_release", 4'b1000);
      step(8'd1,   1'b0, 2'd0, "post_rst_s1",   4'b1000);
      step(8'd255, 1'b0, 2'd0, "post_rst_s255", 4'b1000);

      step(8'd1, 1'b1, 2'd3, "post_acc_during", 4'b1000);
      step(8'd1, 1'b0, 2'd0, "post_acc_after",  4'b0100);

      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clock);
         budget--;
      end
      @(posedge clock);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d checks pending, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lru_tracker.md
Name: lru_tracker

Overview:
- Per-set true-LRU replacement tracker for a set-associative cache.
- Holds an age ordering of WIDTH ways for each of 2^INDEX_BITS sets.
- Outputs the least-recently-used way of the addressed set as a one-hot vector.
- Updates the addressed set's ordering on each valid way access; used by the cache controller to pick a victim way.

Parameters:
- WIDTH, 4, number of ways per set (power of two, >= 2).
- INDEX_BITS, 8, set index width; number of sets = 2^INDEX_BITS.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- current_index  input  INDEX_BITS  set addressed for both lru readout and update.
- access  input  log2(WIDTH)  way number being accessed (hit or fill).
- access_valid  input  1  when high at a rising edge, record an access to way "access" in set current_index.
- lru  output  WIDTH  one-hot; bit i set means way i is LRU in set current_index.

Behaviour:
- State: per set, one age of log2(WIDTH) bits per way. Ages within a set are always a permutation of 0..WIDTH-1; 0 = MRU, WIDTH-1 = LRU.
- Reset (reset low, asynchronous, no clock needed): every set initialises way i to age i.
  - Way WIDTH-1 is LRU in every set; with WIDTH=4, lru = 4'b1000.
  - Reset has priority over access_valid.
  - Reset asserted mid-operation discards all history immediately.
- lru is combinational from the stored ages of set current_index: bit i = 1 iff age[i] == WIDTH-1.
  - Exactly one bit is set at all times outside reset.
  - Changing current_index changes lru in the same cycle.
- Update at a rising edge with reset high and access_valid high, where w = access and s = current_index:
  - Every way in set s whose age < age[w] increments by 1.
  - age[w] becomes 0.
  - Ways with age > age[w] are unchanged, so the permutation is preserved.
  - Accessing the way that is already MRU (age 0) leaves the set unchanged.
  - Other sets are never modified.
- Latency:
  - lru during the update cycle still reflects the pre-update ordering.
  - The new ordering is visible on lru one cycle after the edge.
- access_valid low: no state change.
- Back-to-back accesses on consecutive cycles to the same or different sets are each applied in order, with no bubbles.
- No X propagation: all storage is reset; access is always in range because WIDTH is a power of two.

Test Plan:
- Reset: hold reset low 5 cycles, release, current_index=1 -> lru = 4'b1000; repeat with current_index=0 and 255 -> 4'b1000.
- Access way 2 on set 1 (one-cycle access_valid pulse) -> ages {1,2,0,3}; lru stays 4'b1000 during and after the pulse.
- Then access way 1 and, on the next cycle, way 3 on set 1:
  - After way 1: lru = 4'b1000.
  - One cycle after the way-3 access: lru = 4'b0001 (ages {3,1,2,0}).
- Then access way 2 and then way 0 on set 1:
  - After way 2: lru = 4'b0001.
  - After way 0: ages {0,3,1,2}, lru = 4'b0010.
- Set isolation: after the above, switch current_index to 2 -> lru = 4'b1000; switch back to 1 -> previous value restored.
- Async reset mid-activity: assert reset between clock edges while access_valid=1 -> lru returns to 4'b1000 immediately; no update takes effect while reset is low.
